// File: rtl/axi_rt_cfg_arb_pkg.sv
// Shared definitions for the RT unit register-bus config arbiter.
//   arb_state_e : arbiter FSM states (idle / request outstanding / response)
//   ABORT_RDATA : read data returned to a requester whose access timed out
package axi_rt_cfg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] ABORT_RDATA = 32'h0;

endpackage

// File: rtl/axi_rt_rr_pick.sv
// Combinational rotate-priority picker, reusable by RT arbiters.
// Returns the first set bit of valid_i at or after ptr_i, wrapping modulo NumReq.
//   valid_i : request vector
//   ptr_i   : priority pointer (must be < NumReq)
//   any_o   : at least one request set
//   idx_o   : index of the selected request (0 when any_o is low)
module axi_rt_rr_pick #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumReq-1:0]   valid_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic                any_o,
  output logic [IdxWidth-1:0] idx_o
);

  always_comb begin
    int unsigned cand;
    any_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!any_o && valid_i[cand]) begin
        any_o = 1'b1;
        idx_o = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_rt_cfg_arbiter.sv
// Round-robin arbiter of NumReq register-bus requesters onto the RT unit's
// single cfg port. Request and response are registered; an access stuck in
// REQ for TimeoutCycles cycles is aborted with error=1, rdata=0
// (TimeoutCycles=0 disables the abort).
//   clk_i, rst_i         : clock, synchronous active-high reset
//   req_*_i              : per-requester payload/valid, slice i = requester i
//   req_rdata_o/error_o  : response data, meaningful only with req_ready_o
//   req_ready_o          : one-cycle completion pulse to the winner
//   cfg_*_o / cfg_*_i    : register-bus port towards the RT unit
//   reg_id_o             : winner index, held until the next grant
module axi_rt_cfg_arbiter
  import axi_rt_cfg_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned RegIdWidth    = 2,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq*32-1:0]      req_wdata_i,
  input  logic [NumReq*4-1:0]       req_wstrb_i,
  input  logic [NumReq-1:0]         req_write_i,
  input  logic [NumReq-1:0]         req_valid_i,
  output logic [NumReq*32-1:0]      req_rdata_o,
  output logic [NumReq-1:0]         req_error_o,
  output logic [NumReq-1:0]         req_ready_o,
  output logic [AddrWidth-1:0]      cfg_addr_o,
  output logic [31:0]               cfg_wdata_o,
  output logic [3:0]                cfg_wstrb_o,
  output logic                      cfg_write_o,
  output logic                      cfg_valid_o,
  input  logic [31:0]               cfg_rdata_i,
  input  logic                      cfg_error_i,
  input  logic                      cfg_ready_i,
  output logic [RegIdWidth-1:0]     reg_id_o
);

  localparam int unsigned CntWidth =
    (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  arb_state_e              state_q, state_d;
  logic [RegIdWidth-1:0]   ptr_q, ptr_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic                    write_q, write_d;
  logic                    valid_q, valid_d;
  logic [RegIdWidth-1:0]   id_q, id_d;
  logic [NumReq*32-1:0]    rdata_q, rdata_d;
  logic [NumReq-1:0]       error_q, error_d;
  logic [NumReq-1:0]       ready_q, ready_d;

  logic                    pick_any;
  logic [RegIdWidth-1:0]   pick_idx;
  logic                    timeout_hit;

  axi_rt_rr_pick #(
    .NumReq  (NumReq),
    .IdxWidth(RegIdWidth)
  ) u_pick (
    .valid_i(req_valid_i),
    .ptr_i  (ptr_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  assign timeout_hit = (TimeoutCycles != 0) &&
                       (cnt_q == CntWidth'(TimeoutCycles - 1));

  always_comb begin
    int unsigned widx;
    int unsigned rid;
    widx    = 32'(pick_idx);
    rid     = 32'(id_q);
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    write_d = write_q;
    valid_d = valid_q;
    id_d    = id_q;
    // Response outputs default to zero so that ready/rdata/error live for
    // exactly the one RESP cycle after they are loaded.
    rdata_d = '0;
    error_d = '0;
    ready_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          addr_d  = req_addr_i[widx*AddrWidth +: AddrWidth];
          wdata_d = req_wdata_i[widx*32 +: 32];
          wstrb_d = req_wstrb_i[widx*4 +: 4];
          write_d = req_write_i[widx];
          valid_d = 1'b1;
          id_d    = pick_idx;
          ptr_d   = (widx == NumReq - 1) ? '0 : RegIdWidth'(widx + 1);
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CntWidth'(1);
        // Downstream ready takes precedence over a coinciding timeout.
        if (cfg_ready_i) begin
          valid_d                = 1'b0;
          ready_d[id_q]          = 1'b1;
          rdata_d[rid*32 +: 32]  = cfg_rdata_i;
          error_d[id_q]          = cfg_error_i;
          state_d                = ST_RESP;
        end else if (timeout_hit) begin
          valid_d                = 1'b0;
          ready_d[id_q]          = 1'b1;
          rdata_d[rid*32 +: 32]  = ABORT_RDATA;
          error_d[id_q]          = 1'b1;
          state_d                = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
      rdata_q <= '0;
      error_q <= '0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      write_q <= write_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      ready_q <= ready_d;
    end
  end

  assign cfg_addr_o  = addr_q;
  assign cfg_wdata_o = wdata_q;
  assign cfg_wstrb_o = wstrb_q;
  assign cfg_write_o = write_q;
  assign cfg_valid_o = valid_q;
  assign reg_id_o    = id_q;
  assign req_rdata_o = rdata_q;
  assign req_error_o = error_q;
  assign req_ready_o = ready_q;

endmodule

// File: tb/tb_axi_rt_cfg_arbiter.sv
module tb_axi_rt_cfg_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 2;
  localparam int unsigned T  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N*AW-1:0] req_addr  = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_wstrb = '0;
  logic [N-1:0]    req_write = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_rdata_o;
  logic [N-1:0]    req_error_o;
  logic [N-1:0]    req_ready_o;
  logic [AW-1:0]   cfg_addr_o;
  logic [31:0]     cfg_wdata_o;
  logic [3:0]      cfg_wstrb_o;
  logic            cfg_write_o;
  logic            cfg_valid_o;
  logic [31:0]     cfg_rdata = '0;
  logic            cfg_error = 1'b0;
  logic            cfg_ready = 1'b0;
  logic [IW-1:0]   reg_id_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // responder: ready in the resp_delay-th cycle of cfg_valid_o (0 = never)
  int unsigned resp_delay = 1;
  int unsigned resp_cnt   = 0;

  axi_rt_cfg_arbiter #(
    .NumReq       (N),
    .AddrWidth    (AW),
    .RegIdWidth   (IW),
    .TimeoutCycles(T)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .req_write_i(req_write),
    .req_valid_i(req_valid),
    .req_rdata_o(req_rdata_o),
    .req_error_o(req_error_o),
    .req_ready_o(req_ready_o),
    .cfg_addr_o (cfg_addr_o),
    .cfg_wdata_o(cfg_wdata_o),
    .cfg_wstrb_o(cfg_wstrb_o),
    .cfg_write_o(cfg_write_o),
    .cfg_valid_o(cfg_valid_o),
    .cfg_rdata_i(cfg_rdata),
    .cfg_error_i(cfg_error),
    .cfg_ready_i(cfg_ready),
    .reg_id_o   (reg_id_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic            m_valid = 1'b0;
  logic [IW-1:0]   m_id    = '0;
  logic [AW-1:0]   m_addr  = '0;
  logic [31:0]     m_wdata = '0;
  logic [3:0]      m_wstrb = '0;
  logic            m_write = 1'b0;
  logic [N-1:0]    m_ready = '0;
  logic [N*32-1:0] m_rdata = '0;
  logic [N-1:0]    m_error = '0;
  int unsigned     m_ptr   = 0;
  int unsigned     m_who   = 0;
  int unsigned     m_age   = 0;
  bit              m_busy  = 1'b0;
  bit              m_resp  = 1'b0;
  int unsigned     grant_log[$];

  task automatic model_finish(input logic [31:0] rd, input logic er);
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_resp  = 1'b1;
    m_ready[m_who]           = 1'b1;
    m_rdata[m_who*32 +: 32]  = rd;
    m_error[m_who]           = er;
  endtask

  task automatic model_step();
    bit found;
    int unsigned c;
    if (rst) begin
      m_valid = 1'b0; m_id = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      m_write = 1'b0; m_ready = '0; m_rdata = '0; m_error = '0;
      m_ptr = 0; m_busy = 1'b0; m_resp = 1'b0; m_age = 0;
    end else begin
      m_ready = '0; m_rdata = '0; m_error = '0;
      if (m_resp) begin
        m_resp = 1'b0;
      end else if (m_busy) begin
        m_age++;
        if (cfg_ready) model_finish(cfg_rdata, cfg_error);
        else if (T != 0 && m_age == T) model_finish(32'h0, 1'b1);
      end else begin
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && req_valid[c]) begin
            found   = 1'b1;
            m_who   = c;
            m_valid = 1'b1;
            m_id    = IW'(c);
            m_addr  = req_addr[c*AW +: AW];
            m_wdata = req_wdata[c*32 +: 32];
            m_wstrb = req_wstrb[c*4 +: 4];
            m_write = req_write[c];
            m_ptr   = (c + 1) % N;
            m_busy  = 1'b1;
            m_age   = 0;
            grant_log.push_back(c);
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // compare DUT against model on every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    check("cfg_valid", 128'(cfg_valid_o), 128'(m_valid));
    check("reg_id", 128'(reg_id_o), 128'(m_id));
    check("req_ready", 128'(req_ready_o), 128'(m_ready));
    if (m_valid)
      check("cfg_payload", 128'({cfg_addr_o, cfg_wdata_o, cfg_wstrb_o, cfg_write_o}),
            128'({m_addr, m_wdata, m_wstrb, m_write}));
    if (|m_ready) begin
      check("req_rdata", 128'(req_rdata_o), 128'(m_rdata));
      check("req_error", 128'(req_error_o), 128'(m_error));
    end
  end

  // downstream RT unit responder
  initial forever begin
    @(posedge clk);
    #1;
    if (cfg_valid_o) resp_cnt++;
    else resp_cnt = 0;
    cfg_ready = cfg_valid_o && (resp_delay != 0) && (resp_cnt == resp_delay);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int unsigned i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic w);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4]   = s;
    req_write[i]          = w;
    req_valid[i]          = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    #1;
  endtask

  // waits for requester i's completion; requester drops valid on seeing ready
  task automatic run_one(input int unsigned i, input int unsigned budget,
                         output int unsigned nneg, output int unsigned nvalid,
                         output int unsigned first_id, output logic [31:0] first_addr,
                         output logic [31:0] rd, output logic er);
    bit ok;
    ok = 1'b0; nneg = 0; nvalid = 0; first_id = 99; first_addr = '0; rd = 'x; er = 1'bx;
    while (!ok && nneg < budget) begin
      @(negedge clk);
      nneg++;
      if (cfg_valid_o) begin
        if (nvalid == 0) begin
          first_id   = 32'(reg_id_o);
          first_addr = cfg_addr_o;
        end
        nvalid++;
      end
      if (req_ready_o[i]) begin
        ok = 1'b1;
        rd = req_rdata_o[i*32 +: 32];
        er = req_error_o[i];
      end
    end
    #1;
    req_valid[i] = 1'b0;
    check("ready_seen", 128'(ok), 128'(1));
  endtask

  int unsigned nneg, nvalid, fid;
  logic [31:0] faddr, rd;
  logic        er;
  int unsigned obs_id[$];
  int unsigned obs_k[$];
  int unsigned exp_order[4] = '{0, 1, 3, 0};
  bit          seen;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 128'({cfg_valid_o, req_ready_o, req_error_o, reg_id_o, cfg_write_o}), 128'(0));
    check("reset_data", 128'({cfg_addr_o, cfg_wdata_o, cfg_wstrb_o}), 128'(0));
    check("reset_rdata", 128'(req_rdata_o), 128'(0));
    #1;
    rst = 1'b0;

    // three continuous requesters, one-cycle service
    resp_delay = 1;
    set_req(0, 32'h100, 32'h0000_0000, 4'h1, 1'b1);
    set_req(1, 32'h104, 32'h1111_1111, 4'h3, 1'b0);
    set_req(3, 32'h10C, 32'h3333_3333, 4'hF, 1'b1);
    for (int unsigned k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (cfg_valid_o) begin
        obs_id.push_back(32'(reg_id_o));
        obs_k.push_back(k);
      end
    end
    #1;
    req_valid = '0;
    check("rr_count", 128'(obs_id.size()), 128'(4));
    for (int unsigned j = 0; j < 4; j++) begin
      check("rr_order", 128'(obs_id[j]), 128'(exp_order[j]));
      check("rr_spacing", 128'(obs_k[j]), 128'(1 + 3 * j));
      check("model_order", 128'(grant_log[j]), 128'(exp_order[j]));
    end
    gap();

    // single requester 2 write, ready in the first REQ cycle
    set_req(2, 32'h40, 32'hA5A5_0001, 4'hF, 1'b1);
    run_one(2, 20, nneg, nvalid, fid, faddr, rd, er);
    check("t1_latency", 128'(nneg), 128'(2));
    check("t1_valid_cycles", 128'(nvalid), 128'(1));
    check("t1_reg_id", 128'(fid), 128'(2));
    check("t1_addr", 128'(faddr), 128'(32'h40));
    check("t1_error", 128'(er), 128'(0));
    gap();

    // read, ready after 5 cycles
    resp_delay = 5;
    cfg_rdata  = 32'h1234_5678;
    cfg_error  = 1'b0;
    set_req(1, 32'h44, 32'h0, 4'h0, 1'b0);
    run_one(1, 20, nneg, nvalid, fid, faddr, rd, er);
    check("t3_valid_cycles", 128'(nvalid), 128'(5));
    check("t3_latency", 128'(nneg), 128'(6));
    check("t3_rdata", 128'(rd), 128'(32'h1234_5678));
    check("t3_reg_id", 128'(fid), 128'(1));
    gap();

    // timeout: requester 3 aborted, requester 0 served next
    resp_delay = 0;
    cfg_rdata  = 32'hDEAD_BEEF;
    set_req(3, 32'h48, 32'h3, 4'h1, 1'b1);
    set_req(0, 32'h4C, 32'h4, 4'h2, 1'b1);
    run_one(3, 30, nneg, nvalid, fid, faddr, rd, er);
    check("t4_reg_id", 128'(fid), 128'(3));
    check("t4_valid_cycles", 128'(nvalid), 128'(8));
    check("t4_latency", 128'(nneg), 128'(9));
    check("t4_rdata", 128'(rd), 128'(0));
    check("t4_error", 128'(er), 128'(1));
    resp_delay = 1;
    run_one(0, 20, nneg, nvalid, fid, faddr, rd, er);
    check("t4_next_id", 128'(fid), 128'(0));
    check("t4_next_rdata", 128'(rd), 128'(32'hDEAD_BEEF));
    check("t4_next_error", 128'(er), 128'(0));
    gap();

    // ready coincides with the timeout cycle: normal response wins
    resp_delay = 8;
    cfg_rdata  = 32'hCAFE_0005;
    cfg_error  = 1'b1;
    set_req(2, 32'h50, 32'h5, 4'h8, 1'b0);
    run_one(2, 30, nneg, nvalid, fid, faddr, rd, er);
    check("t5_valid_cycles", 128'(nvalid), 128'(8));
    check("t5_rdata", 128'(rd), 128'(32'hCAFE_0005));
    check("t5_error", 128'(er), 128'(1));
    cfg_error = 1'b0;
    gap();

    // reset while in REQ
    resp_delay = 0;
    set_req(2, 32'h54, 32'h6, 4'hF, 1'b1);
    seen = 1'b0;
    for (int unsigned k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = cfg_valid_o;
    end
    check("t6_in_req", 128'(seen), 128'(1));
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("t6_rst_ctrl", 128'({cfg_valid_o, req_ready_o, req_error_o, reg_id_o, cfg_write_o}), 128'(0));
    check("t6_rst_data", 128'({cfg_addr_o, cfg_wdata_o, cfg_wstrb_o}), 128'(0));
    #1;
    rst        = 1'b0;
    resp_delay = 1;
    set_req(0, 32'h60, 32'h7, 4'h1, 1'b1);
    set_req(3, 32'h6C, 32'h8, 4'h2, 1'b0);
    run_one(0, 20, nneg, nvalid, fid, faddr, rd, er);
    check("t6_first_id", 128'(fid), 128'(0));
    check("t6_latency", 128'(nneg), 128'(2));
    run_one(3, 20, nneg, nvalid, fid, faddr, rd, er);
    check("t6_second_id", 128'(fid), 128'(3));

    gap();
    gap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_rt_cfg_arbiter.md
Name: axi_rt_cfg_arbiter

Overview:
- Upstream neighbour of the RT unit's register-bus config port.
- Arbitrates NumReq independent register-bus requesters (e.g. per-core drivers) onto the single cfg port, round-robin.
- Drives the RT unit's reg_id with the winner's index.
- Registers the request and the response, and aborts hung transactions with an error after a configurable timeout.

Parameters:
- NumReq, 4, number of upstream requesters (2..2**RegIdWidth)
- AddrWidth, 32, cfg address width
- RegIdWidth, 2, width of reg_id_o
- TimeoutCycles, 256, cycles in REQ before abort; 0 disables timeout
- CntWidth, derived clog2(TimeoutCycles+1), timeout counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_addr_i  in  NumReq*AddrWidth  per-requester address, slice i = requester i
- req_wdata_i  in  NumReq*32  per-requester write data
- req_wstrb_i  in  NumReq*4  per-requester byte strobes
- req_write_i  in  NumReq  1=write, 0=read
- req_valid_i  in  NumReq  request valid
- req_rdata_o  out  NumReq*32  read data, valid only with req_ready_o
- req_error_o  out  NumReq  error, valid only with req_ready_o
- req_ready_o  out  NumReq  one-cycle completion pulse
- cfg_addr_o  out  AddrWidth  to RT unit
- cfg_wdata_o  out  32  to RT unit
- cfg_wstrb_o  out  4  to RT unit
- cfg_write_o  out  1  to RT unit
- cfg_valid_o  out  1  to RT unit
- cfg_rdata_i  in  32  from RT unit
- cfg_error_i  in  1  from RT unit
- cfg_ready_i  in  1  from RT unit
- reg_id_o  out  RegIdWidth  winner index, to RT unit reg_id_i

Behaviour:
- Reset (rst_i high at a clock edge, regardless of state) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - round-robin pointer to 0;
  - timeout counter to 0.
- Reset mid-transaction drops cfg_valid_o at the next edge, with no response to the requester.
- Register-bus rule, upstream: a requester holds valid and payload stable until it sees ready. The arbiter never checks this.
- FSM states:
  - IDLE:
    - If any req_valid_i is set, the winner is the first set bit at or after the pointer, wrapping modulo NumReq.
    - Capture the winner's payload into output registers, set reg_id_o = winner index, set cfg_valid_o=1, go to REQ.
    - Pointer becomes winner+1 mod NumReq.
    - With no valid, stay in IDLE.
  - REQ:
    - cfg_* outputs are held stable; the counter increments each cycle.
    - If cfg_ready_i=1: capture cfg_rdata_i and cfg_error_i, drop cfg_valid_o, go to RESP.
    - Else if TimeoutCycles!=0 and the counter reaches TimeoutCycles-1: drop cfg_valid_o, load rdata=32'h0 and error=1, go to RESP.
    - If ready and timeout coincide in the same cycle, ready wins (normal response).
  - RESP:
    - Assert req_ready_o[winner]=1 with registered rdata/error for exactly one cycle, clear the counter, go to IDLE.
- Latency with downstream ready in the first REQ cycle:
  - request sampled at edge 0;
  - cfg_valid_o high in cycle 1;
  - req_ready_o high in cycle 2.
- In general, completion comes one cycle after cfg_ready_i.
- Minimum spacing between grants is 3 cycles (IDLE, REQ, RESP).
- The served requester is not re-granted while others are waiting, because the pointer moves past it. A lone requester is re-granted in the next IDLE.
- req_rdata_o and req_error_o for non-winners are 0. Only one bit of req_ready_o is ever set.
- reg_id_o keeps its value after RESP until the next grant; only cfg_valid_o qualifies it.
- A 32-bit reg data width is fixed.

Decomposition:
- Package axi_rt_cfg_arb_pkg holds:
  - the state enum (IDLE, REQ, RESP);
  - the abort rdata constant 32'h0.
- Sub-module axi_rt_rr_pick: combinational rotate-priority picker.
  - Inputs: valid vector, pointer.
  - Outputs: any, index.
  - Reusable by other RT arbiters.

Test Plan:
- Single requester 2 writes addr 0x40, data 0xA5A5_0001, strobe 0xF; RT unit ready in the first REQ cycle -> cfg_valid_o high one cycle with matching payload and reg_id_o=2; req_ready_o[2] pulses two cycles after the request is sampled with error=0.
- Requesters 0, 1, 3 all valid continuously, each serviced in a single cycle -> grant order 0, 1, 3, 0 …; a new grant every 3 cycles; reg_id_o follows the grant order.
- Read, ready after 5 cycles with rdata 0x1234_5678 -> cfg_valid_o stable for 5 cycles; req_rdata_o[winner]=0x1234_5678 for one cycle after ready.
- TimeoutCycles=8, cfg_ready_i held low -> cfg_valid_o drops after 8 REQ cycles; req_ready_o pulse with error=1, rdata=0; the next requester is then granted.
- Ready arrives in the same cycle the timeout expires -> normal response, error equals cfg_error_i.
- rst_i asserted in REQ -> next cycle all outputs 0 and no req_ready_o; after release, requester 0 is granted first (pointer reset).
